// File: rtl/tcdm_amo_responder.sv
// TCDM bank responder: loads, byte-masked stores, RISC-V AMOs and LR/SC on a local SRAM.
// Define TCDM_RESPONDER_ERR_EN to flag out-of-range addresses instead of wrapping them.
module tcdm_amo_responder #(
  parameter int unsigned NumWords  = 1024,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int unsigned IdWidth   = 5,
  parameter int unsigned RespDepth = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        data_qaddr_i,
  input  logic               data_qwrite_i,
  input  logic [3:0]         data_qamo_i,
  input  logic [31:0]        data_qdata_i,
  input  logic [3:0]         data_qstrb_i,
  input  logic [IdWidth-1:0] data_qid_i,
  input  logic               data_qlrwait_i,
  input  logic               data_qvalid_i,
  output logic               data_qready_o,
  output logic [31:0]        data_pdata_o,
  output logic               data_perror_o,
  output logic [IdWidth-1:0] data_pid_o,
  output logic               data_plrwait_o,
  output logic               data_pvalid_o,
  input  logic               data_pready_i
);
  localparam int unsigned AW = $clog2(NumWords);
  localparam int unsigned PW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CW = $clog2(RespDepth + 1) + 1;

  typedef enum logic [1:0] {KLoad, KAmo, KSc, KErr} kind_e;
  typedef struct packed {
    logic [31:0]        data;
    logic               err;
    logic [IdWidth-1:0] id;
    logic               lrwait;
  } resp_t;

  logic [31:0]        mem_q [NumWords];
  logic [31:0]        off;
  logic [AW-1:0]      q_idx;
  logic               q_err, q_is_amo, q_lr, q_sc, q_store, sc_ok, accept, amo_wb;
  logic               unused_bits;

  logic               st_vld_q, st_vld_d;
  kind_e              st_kind_q, st_kind_d;
  logic [IdWidth-1:0] st_id_q;
  logic               st_lrw_q, st_scfail_q;
  logic [AW-1:0]      st_idx_q;
  logic [31:0]        st_opnd_q, st_rd_q, amo_new;
  logic [3:0]         st_amo_q;
  resp_t              st_resp, head;

  logic               we;
  logic [AW-1:0]      widx;
  logic [31:0]        wdata;
  logic [3:0]         wstrb;

  logic               resv_vld_q, resv_vld_d;
  logic [AW-1:0]      resv_idx_q, resv_idx_d;
  logic [IdWidth-1:0] resv_id_q, resv_id_d;

  resp_t              fifo_q [RespDepth];
  logic [PW-1:0]      rptr_q, wptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop_fifo, p_vld;

  assign off         = data_qaddr_i - BaseAddr;
  assign q_idx       = off[2 +: AW];
  assign unused_bits = ^{off[1:0], off[31:AW+2]};
`ifdef TCDM_RESPONDER_ERR_EN
  assign q_err = (off[31:AW+2] != '0);
`else
  assign q_err = 1'b0;
`endif

  assign q_is_amo = (data_qamo_i >= 4'h1) && (data_qamo_i <= 4'h9);
  assign q_lr     = (data_qamo_i == 4'hA);
  assign q_sc     = (data_qamo_i == 4'hB);
  assign q_store  = data_qwrite_i && (data_qamo_i == 4'h0);
  assign sc_ok    = resv_vld_q && (resv_idx_q == q_idx) && (resv_id_q == data_qid_i);
  assign amo_wb   = st_vld_q && (st_kind_q == KAmo);

  // Occupancy counts the staged response so an accept can never overflow the FIFO.
  assign data_qready_o = !rst_i && !amo_wb && ((count_q + CW'(st_vld_q)) < CW'(RespDepth));
  assign accept        = data_qvalid_i && data_qready_o;

  always_comb begin
    case (st_amo_q)
      4'h1:    amo_new = st_opnd_q;
      4'h2:    amo_new = st_rd_q + st_opnd_q;
      4'h3:    amo_new = st_rd_q & st_opnd_q;
      4'h4:    amo_new = st_rd_q | st_opnd_q;
      4'h5:    amo_new = st_rd_q ^ st_opnd_q;
      4'h6:    amo_new = ($signed(st_rd_q) > $signed(st_opnd_q)) ? st_rd_q : st_opnd_q;
      4'h7:    amo_new = (st_rd_q > st_opnd_q) ? st_rd_q : st_opnd_q;
      4'h8:    amo_new = ($signed(st_rd_q) < $signed(st_opnd_q)) ? st_rd_q : st_opnd_q;
      4'h9:    amo_new = (st_rd_q < st_opnd_q) ? st_rd_q : st_opnd_q;
      default: amo_new = st_opnd_q;
    endcase
  end

  // Single write port: AMO write-back blocks accepts, so the two sources never collide.
  always_comb begin
    we    = 1'b0;
    widx  = q_idx;
    wdata = data_qdata_i;
    wstrb = '1;
    if (amo_wb) begin
      we    = 1'b1;
      widx  = st_idx_q;
      wdata = amo_new;
    end else if (accept && !q_err) begin
      if (q_store) begin
        we    = 1'b1;
        wstrb = data_qstrb_i;
      end else if (q_sc && sc_ok) begin
        we = 1'b1;
      end
    end
    we = we && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (accept) st_rd_q <= mem_q[q_idx];
  end

  always_comb begin
    st_vld_d  = accept && !q_store;
    st_kind_d = KLoad;
    if (q_err)         st_kind_d = KErr;
    else if (q_sc)     st_kind_d = KSc;
    else if (q_is_amo) st_kind_d = KAmo;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_vld_q    <= 1'b0;
      st_kind_q   <= KLoad;
      st_id_q     <= '0;
      st_lrw_q    <= 1'b0;
      st_scfail_q <= 1'b0;
      st_idx_q    <= '0;
      st_opnd_q   <= '0;
      st_amo_q    <= '0;
    end else begin
      st_vld_q <= st_vld_d;
      if (accept) begin
        st_kind_q   <= st_kind_d;
        st_id_q     <= data_qid_i;
        st_lrw_q    <= data_qlrwait_i;
        st_scfail_q <= !sc_ok;
        st_idx_q    <= q_idx;
        st_opnd_q   <= data_qdata_i;
        st_amo_q    <= data_qamo_i;
      end
    end
  end

  always_comb begin
    resv_vld_d = resv_vld_q;
    resv_idx_d = resv_idx_q;
    resv_id_d  = resv_id_q;
    if (accept && !q_err) begin
      if (q_lr) begin
        resv_vld_d = 1'b1;
        resv_idx_d = q_idx;
        resv_id_d  = data_qid_i;
      end else if (q_sc || (q_store && (resv_idx_q == q_idx))) begin
        resv_vld_d = 1'b0;
      end
    end
    if (amo_wb && (resv_idx_q == st_idx_q)) resv_vld_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_vld_q <= 1'b0;
      resv_idx_q <= '0;
      resv_id_q  <= '0;
    end else begin
      resv_vld_q <= resv_vld_d;
      resv_idx_q <= resv_idx_d;
      resv_id_q  <= resv_id_d;
    end
  end

  always_comb begin
    st_resp.data   = st_rd_q;
    st_resp.err    = (st_kind_q == KErr);
    st_resp.id     = st_id_q;
    st_resp.lrwait = st_lrw_q;
    if (st_kind_q == KSc)  st_resp.data = {31'b0, st_scfail_q};
    if (st_kind_q == KErr) st_resp.data = '0;
  end

  // Fall-through: with an empty FIFO the staged response is presented directly and
  // only pushed if it is not consumed, which keeps the p outputs stable under stall.
  assign p_vld    = (count_q != '0) || st_vld_q;
  assign head     = (count_q != '0) ? fifo_q[rptr_q] : st_resp;
  assign pop_fifo = (count_q != '0) && data_pready_i;
  assign push     = st_vld_q && !((count_q == '0) && data_pready_i);
  assign count_d  = count_q + CW'(push) - CW'(pop_fifo);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push)     wptr_q <= (wptr_q == PW'(RespDepth - 1)) ? '0 : wptr_q + 1'b1;
      if (pop_fifo) rptr_q <= (rptr_q == PW'(RespDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) fifo_q[wptr_q] <= st_resp;
  end

  assign data_pvalid_o  = !rst_i && p_vld;
  assign data_pdata_o   = rst_i ? '0 : head.data;
  assign data_perror_o  = !rst_i && p_vld && head.err;
  assign data_pid_o     = rst_i ? '0 : head.id;
  assign data_plrwait_o = !rst_i && head.lrwait;
endmodule

// File: tb/tb_tcdm_amo_responder.sv
// Directed self-checking bench for tcdm_amo_responder (default parameters).
module tb_tcdm_amo_responder;
  localparam int unsigned IW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   data_qaddr_i;
  logic          data_qwrite_i;
  logic [3:0]    data_qamo_i;
  logic [31:0]   data_qdata_i;
  logic [3:0]    data_qstrb_i;
  logic [IW-1:0] data_qid_i;
  logic          data_qlrwait_i;
  logic          data_qvalid_i;
  logic          data_qready_o;
  logic [31:0]   data_pdata_o;
  logic          data_perror_o;
  logic [IW-1:0] data_pid_o;
  logic          data_plrwait_o;
  logic          data_pvalid_o;
  logic          data_pready_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  tcdm_amo_responder #(.NumWords(1024), .BaseAddr(32'h0), .IdWidth(IW), .RespDepth(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_qaddr_i(data_qaddr_i), .data_qwrite_i(data_qwrite_i), .data_qamo_i(data_qamo_i),
    .data_qdata_i(data_qdata_i), .data_qstrb_i(data_qstrb_i), .data_qid_i(data_qid_i),
    .data_qlrwait_i(data_qlrwait_i), .data_qvalid_i(data_qvalid_i), .data_qready_o(data_qready_o),
    .data_pdata_o(data_pdata_o), .data_perror_o(data_perror_o), .data_pid_o(data_pid_o),
    .data_plrwait_o(data_plrwait_o), .data_pvalid_o(data_pvalid_o), .data_pready_i(data_pready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] amo,
                       input logic [31:0] d, input logic [3:0] s, input logic [IW-1:0] id,
                       input logic lw);
    data_qaddr_i = a; data_qwrite_i = w; data_qamo_i = amo; data_qdata_i = d;
    data_qstrb_i = s; data_qid_i = id; data_qlrwait_i = lw; data_qvalid_i = 1'b1;
  endtask

  // Holds the request until accepted; returns at edge+1 of the cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] amo,
                      input logic [31:0] d, input logic [3:0] s, input logic [IW-1:0] id);
    bit acc = 0;
    int n = 0;
    drive(a, w, amo, d, s, id, 1'b0);
    while (!acc && n < 20) begin
      #4;
      acc = data_qready_o;
      cyc();
      n++;
    end
    data_qvalid_i = 1'b0;
    if (!acc) begin
      total_cnt++;
      $display("FAIL send_timeout: addr %h not accepted within 20 cycles", a);
    end
  endtask

  task automatic recv(output logic [31:0] d, output logic e, output logic [IW-1:0] id,
                      output int lat);
    bit got = 0;
    lat = 0; d = '0; e = 1'b0; id = '0;
    data_pready_i = 1'b1;
    while (!got && lat < 20) begin
      #4;
      if (data_pvalid_o) begin
        got = 1; d = data_pdata_o; e = data_perror_o; id = data_pid_o;
      end
      cyc();
      lat++;
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL recv_timeout: no response within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; data_pready_i = 1'b1;
    drive(32'h0, 1'b0, 4'h0, 32'h0, 4'h0, '0, 1'b0);
    data_qvalid_i = 1'b0;
    cyc(); cyc(); #4;
    total_cnt++;
    if (data_qready_o !== 1'b0 || data_pvalid_o !== 1'b0)
      $display("FAIL reset_outputs: qready=%b pvalid=%b, need 0/0", data_qready_o, data_pvalid_o);
    else pass_cnt++;
    cyc(); rst_i = 1'b0; #4;
    total_cnt++;
    if (data_qready_o !== 1'b1 || data_pvalid_o !== 1'b0)
      $display("FAIL post_reset: qready=%b pvalid=%b, need 1/0", data_qready_o, data_pvalid_o);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_load_store();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    drive(32'h10, 1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 5'd9, 1'b0);
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b1) $display("FAIL store_ready: qready=%b need 1", data_qready_o);
    else pass_cnt++;
    cyc();
    drive(32'h10, 1'b0, 4'h0, 32'h0, 4'h0, 5'd3, 1'b1);
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b0) $display("FAIL store_no_resp: pvalid=%b need 0", data_pvalid_o);
    else pass_cnt++;
    cyc();
    data_qvalid_i = 1'b0;
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b1 || data_pdata_o !== 32'hDEADBEEF || data_pid_o !== 5'd3 ||
        data_plrwait_o !== 1'b1)
      $display("FAIL load_after_store: pvalid=%b pdata=%h pid=%0d lrw=%b need 1/DEADBEEF/3/1",
               data_pvalid_o, data_pdata_o, data_pid_o, data_plrwait_o);
    else pass_cnt++;
    cyc();
    send(32'h10, 1'b1, 4'h0, 32'h11223344, 4'b0101, 5'd0);
    send(32'h10, 1'b0, 4'h0, 32'h0, 4'h0, 5'd4);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'hDE22BE44 || id !== 5'd4 || lat != 1 || e !== 1'b0)
      $display("FAIL strb_store: pdata=%h pid=%0d lat=%0d err=%b need DE22BE44/4/1/0", d, id, lat, e);
    else pass_cnt++;
  endtask

  task automatic test_amo_add();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    send(32'h20, 1'b1, 4'h0, 32'd5, 4'hF, 5'd0);
    send(32'h20, 1'b0, 4'h2, 32'd7, 4'h0, 5'd5);
    drive(32'h20, 1'b0, 4'h0, 32'h0, 4'h0, 5'd6, 1'b0);
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b0 || data_pvalid_o !== 1'b1 || data_pdata_o !== 32'd5 || data_pid_o !== 5'd5)
      $display("FAIL amo_wb: qready=%b pvalid=%b pdata=%h pid=%0d need 0/1/5/5",
               data_qready_o, data_pvalid_o, data_pdata_o, data_pid_o);
    else pass_cnt++;
    cyc();
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b1 || data_pvalid_o !== 1'b0)
      $display("FAIL amo_after_wb: qready=%b pvalid=%b need 1/0", data_qready_o, data_pvalid_o);
    else pass_cnt++;
    cyc();
    data_qvalid_i = 1'b0;
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd12 || id !== 5'd6 || lat != 1)
      $display("FAIL amo_add_result: pdata=%h pid=%0d lat=%0d need 0000000c/6/1", d, id, lat);
    else pass_cnt++;
  endtask

  task automatic test_amo_ops();
    logic [3:0]  op [9]   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [31:0] ini [9]  = '{32'd5, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 32'hFF,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] opn [9]  = '{32'd9, 32'd2, 32'h0000FF00, 32'h0000FF00, 32'h0F,
                              32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] expn [9] = '{32'd9, 32'd1, 32'h0000F000, 32'h0000FFF0, 32'hF0,
                              32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    for (int i = 0; i < 9; i++) begin
      send(32'h40, 1'b1, 4'h0, ini[i], 4'hF, 5'd0);
      send(32'h40, 1'b0, op[i], opn[i], 4'h0, 5'd12);
      recv(d, e, id, lat);
      total_cnt++;
      if (d !== ini[i] || id !== 5'd12)
        $display("FAIL amo_old_op%0h: pdata=%h pid=%0d need %h/12", op[i], d, id, ini[i]);
      else pass_cnt++;
      send(32'h40, 1'b0, 4'h0, 32'h0, 4'h0, 5'd13);
      recv(d, e, id, lat);
      total_cnt++;
      if (d !== expn[i]) $display("FAIL amo_new_op%0h: mem=%h need %h", op[i], d, expn[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lrsc();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    send(32'h30, 1'b1, 4'h0, 32'h12345678, 4'hF, 5'd0);
    send(32'h30, 1'b0, 4'hA, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'h12345678) $display("FAIL lr_data: pdata=%h need 12345678", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'hB, 32'hAAAA0001, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL sc_success: pdata=%h need 0", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'h0, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'hAAAA0001) $display("FAIL sc_write: mem=%h need AAAA0001", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'hA, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    send(32'h30, 1'b1, 4'h0, 32'hBBBB0002, 4'hF, 5'd2);
    send(32'h30, 1'b0, 4'hB, 32'hCCCC0003, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL sc_after_store: pdata=%h need 1", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'h0, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'hBBBB0002) $display("FAIL sc_fail_nowrite: mem=%h need BBBB0002", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'hA, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    send(32'h30, 1'b0, 4'hB, 32'h0, 4'h0, 5'd2);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL sc_wrong_id: pdata=%h need 1", d);
    else pass_cnt++;
    send(32'h30, 1'b0, 4'hA, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    send(32'h34, 1'b1, 4'h0, 32'h5555, 4'hF, 5'd2);
    send(32'h30, 1'b0, 4'hB, 32'h0000DDDD, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd0) $display("FAIL sc_other_word_kept: pdata=%h need 0", d);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    int acc = 0;
    for (int k = 0; k < 4; k++) send(32'h100 + 32'(4 * k), 1'b1, 4'h0, 32'hA0 + 32'(k), 4'hF, 5'd0);
    data_pready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (acc < 4) drive(32'h100 + 32'(4 * acc), 1'b0, 4'h0, 32'h0, 4'h0, 5'(10 + acc), 1'b0);
      #4;
      if (data_qready_o) acc++;
      cyc();
    end
    data_qvalid_i = 1'b0;
    #4;
    total_cnt++;
    if (acc != 2 || data_qready_o !== 1'b0 || data_pid_o !== 5'd10 || data_pdata_o !== 32'hA0)
      $display("FAIL bp_full: accepted=%0d qready=%b pid=%0d pdata=%h need 2/0/10/a0",
               acc, data_qready_o, data_pid_o, data_pdata_o);
    else pass_cnt++;
    cyc();
    for (int k = 0; k < 2; k++) begin
      recv(d, e, id, lat);
      total_cnt++;
      if (id !== 5'(10 + k) || d !== 32'hA0 + 32'(k))
        $display("FAIL bp_order%0d: pid=%0d pdata=%h need %0d/%h", k, id, d, 10 + k, 32'hA0 + 32'(k));
      else pass_cnt++;
    end
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b0) $display("FAIL bp_no_dup: pvalid=%b need 0", data_pvalid_o);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    send(32'h70, 1'b1, 4'h0, 32'd0, 4'hF, 5'd0);
    drive(32'h70, 1'b0, 4'h2, 32'd1, 4'h0, 5'd7, 1'b0);
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b1) $display("FAIL b2b_first: qready=%b need 1", data_qready_o);
    else pass_cnt++;
    cyc();
    data_qid_i = 5'd8;
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b0 || data_pvalid_o !== 1'b1 || data_pdata_o !== 32'd0 || data_pid_o !== 5'd7)
      $display("FAIL b2b_wb1: qready=%b pvalid=%b pdata=%h pid=%0d need 0/1/0/7",
               data_qready_o, data_pvalid_o, data_pdata_o, data_pid_o);
    else pass_cnt++;
    cyc();
    #4;
    total_cnt++;
    if (data_qready_o !== 1'b1) $display("FAIL b2b_second: qready=%b need 1", data_qready_o);
    else pass_cnt++;
    cyc();
    data_qvalid_i = 1'b0;
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b1 || data_pdata_o !== 32'd1 || data_pid_o !== 5'd8)
      $display("FAIL b2b_wb2: pvalid=%b pdata=%h pid=%0d need 1/1/8", data_pvalid_o, data_pdata_o, data_pid_o);
    else pass_cnt++;
    cyc();
    send(32'h70, 1'b0, 4'h0, 32'h0, 4'h0, 5'd9);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd2) $display("FAIL b2b_result: mem=%h need 2", d);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    send(32'h50, 1'b1, 4'h0, 32'h77, 4'hF, 5'd0);
    send(32'h60, 1'b0, 4'hA, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    data_pready_i = 1'b0;
    send(32'h10, 1'b0, 4'h0, 32'h0, 4'h0, 5'd20);
    send(32'h50, 1'b0, 4'h2, 32'd1, 4'h0, 5'd21);
    rst_i = 1'b1;
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b0 || data_qready_o !== 1'b0)
      $display("FAIL rst_mid_outputs: pvalid=%b qready=%b need 0/0", data_pvalid_o, data_qready_o);
    else pass_cnt++;
    cyc();
    rst_i = 1'b0;
    data_pready_i = 1'b1;
    #4;
    total_cnt++;
    if (data_pvalid_o !== 1'b0 || data_qready_o !== 1'b1)
      $display("FAIL rst_mid_flushed: pvalid=%b qready=%b need 0/1", data_pvalid_o, data_qready_o);
    else pass_cnt++;
    cyc();
    send(32'h60, 1'b0, 4'hB, 32'h0, 4'h0, 5'd1);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'd1) $display("FAIL rst_sc: pdata=%h need 1", d);
    else pass_cnt++;
    send(32'h50, 1'b0, 4'h0, 32'h0, 4'h0, 5'd2);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'h77) $display("FAIL rst_amo_dropped: mem=%h need 77", d);
    else pass_cnt++;
    send(32'h10, 1'b0, 4'h0, 32'h0, 4'h0, 5'd3);
    recv(d, e, id, lat);
    total_cnt++;
    if (d !== 32'hDE22BE44) $display("FAIL rst_sram_kept: mem=%h need DE22BE44", d);
    else pass_cnt++;
  endtask

  task automatic test_range();
    logic [31:0] d; logic e; logic [IW-1:0] id; int lat;
    send(32'h0, 1'b1, 4'h0, 32'h0BADF00D, 4'hF, 5'd0);
    send(32'h1000, 1'b0, 4'h0, 32'h0, 4'h0, 5'd17);
    recv(d, e, id, lat);
`ifdef TCDM_RESPONDER_ERR_EN
    total_cnt++;
    if (e !== 1'b1 || d !== 32'd0 || id !== 5'd17)
      $display("FAIL range_error: err=%b pdata=%h pid=%0d need 1/0/17", e, d, id);
    else pass_cnt++;
`else
    total_cnt++;
    if (e !== 1'b0 || d !== 32'h0BADF00D || id !== 5'd17)
      $display("FAIL range_alias: err=%b pdata=%h pid=%0d need 0/0badf00d/17", e, d, id);
    else pass_cnt++;
`endif
  endtask

  initial begin
    data_pready_i = 1'b1;
    rst_i = 1'b1;
    data_qvalid_i = 1'b0;
    cyc();
    test_reset();
    test_load_store();
    test_amo_add();
    test_amo_ops();
    test_lrsc();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
